prim_clock_gate_ctrl: RTL and testbench
=======================================

# prim_clock_gate_ctrl

Sequencer for a shared gated clock. It arbitrates enable requests from `NumReq` clients and drives the enable of one downstream clock gate/buffer cell. It guarantees a fixed wake-up settle time before granting, and a fixed idle hysteresis before gating the clock off. It runs on the free-running clock, upstream of the gate it controls.

## Interface
- `NumReq`, default 4: number of requesters, at least 1.
- `WakeCycles`, default 2: cycles `en_o` is held high before any grant, at least 1.
- `IdleCycles`, default 8: idle cycles with `en_o` still high before gating off, at least 1.
- `clk_i` input, 1 bit: free-running clock, single clock domain.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `req_i` input, `NumReq` bits: level request per client. Held until the client is done.
- `force_on_i` input, 1 bit: keep the clock enabled. Behaves as an extra requester with no ack.
- `ack_o` output, `NumReq` bits: per-client grant. The gated clock is stable while this is high.
- `en_o` output, 1 bit: enable to the clock gate cell.
- `busy_o` output, 1 bit: the FSM is not in OFF.
- `off_pulse_o` output, 1 bit: one-cycle pulse on the first cycle of OFF after HOLD.

## Operation
- `any_req = |req_i | force_on_i`.
- The FSM has four states: OFF, WAKE, ON, HOLD. Reset state is OFF.
- **OFF**
  - `en_o` is 0.
  - If `any_req`, go to WAKE and load the counter with `WakeCycles-1`.
- **WAKE**
  - `en_o` is 1.
  - The counter decrements each cycle.
  - When the counter is 0, go to ON. WAKE therefore lasts exactly `WakeCycles` cycles.
  - WAKE always completes, even if every request drops during it.
- **ON**
  - `en_o` is 1.
  - If `!any_req`, go to HOLD and load the counter with `IdleCycles-1`.
- **HOLD**
  - `en_o` is 1.
  - If `any_req`, go to ON; the counter is don't-care.
  - Otherwise, when the counter is 0, go to OFF. HOLD lasts exactly `IdleCycles` cycles with no requests.
  - A request takes priority over the counter reaching 0 in the same cycle.
- **Outputs**
  - `ack_o = req_i & {NumReq{state_q == ON}}`. This is combinational from registered state, so an ack falls in the same cycle its request falls.
  - `en_o` is 1 when `state_q != OFF`. It is a decode of registered state only, with no logic from inputs (glitch-free to the gate).
  - `busy_o` is 1 when `state_q != OFF`.
  - `off_pulse_o` is registered. It is 1 for exactly the first cycle of OFF entered from HOLD.
- **Counter**
  - Width is `$clog2(max(WakeCycles, IdleCycles)) + 1`, with no wrap.
  - It decrements only in WAKE or HOLD, and only while nonzero.
- **Reset**
  - Asserting `rst_ni` mid-operation immediately forces OFF, counter 0, `off_pulse_o` 0.
  - `ack_o` and `en_o` go low asynchronously.
- **Requests**
  - Requests are not prioritised: all requesting clients are acked together in ON.
  - A new request arriving in ON is acked in the same cycle.

## Timing
- Cycle 0 is the cycle in which `any_req` is first sampled high.
- **From OFF**
  - `en_o` rises in cycle 1.
  - The FSM is in WAKE for cycles 1 through `WakeCycles`.
  - `ack_o` rises in cycle `WakeCycles+1`.
- **From HOLD**
  - `ack_o` rises in cycle 1.
  - `en_o` stays high throughout.
- **Release**
  - The last request falls in cycle r while in ON; `ack_o` is low in cycle r.
  - The FSM is in HOLD for cycles r+1 through r+`IdleCycles`.
  - OFF, `en_o`=0 and `off_pulse_o`=1 occur in cycle r+`IdleCycles`+1.
- **Reset values:** `ack_o`=0, `en_o`=0, `busy_o`=0, `off_pulse_o`=0.

## Test plan
- **Cold request** (WakeCycles=2, IdleCycles=3): `req_i`=4'b0001 raised in cycle 0.
  - `en_o`=1 from cycle 1.
  - `ack_o`=4'b0001 from cycle 3, not before.
- **Idle gate-off:** from the previous test, drop `req_i` in cycle 5.
  - `ack_o`=0 in cycle 5.
  - HOLD in cycles 6–8.
  - `en_o`=0 and `off_pulse_o`=1 in cycle 9; `off_pulse_o`=0 in cycle 10.
- **Re-request in HOLD:** `req_i`=4'b0100 raised in the second HOLD cycle.
  - `ack_o`=4'b0100 in the next cycle.
  - `en_o` never drops.
  - No `off_pulse_o`.
- **Request drop during WAKE:** a `req_i` pulse of one cycle in OFF.
  - WAKE runs for the full 2 cycles, then 1 cycle of ON, then 3 cycles of HOLD, then OFF.
  - `ack_o` stays 0 throughout.
- **Force and multi-client:** hold `force_on_i`=1 while `req_i` toggles between 4'b1010 and 0.
  - `en_o` stays 1 continuously.
  - `ack_o` tracks `req_i` combinationally in ON.
  - Releasing force with no requests gives OFF after `IdleCycles`+1.
- **Async reset:** assert `rst_ni`=0 mid-WAKE and again mid-ON.
  - `en_o`, `ack_o` and `busy_o` go to 0 without a clock edge.
  - After release with `req_i` held, the full `WakeCycles` latency is repeated.

Source files
------------

// File: rtl/prim_clock_gate_ctrl.sv
// prim_clock_gate_ctrl
// ---------------------------------------------------------------------------
// Controls one shared gated clock. The enables from NumReq clients and a
// force-on input are combined. The block then drives the enable of one
// downstream clock gate cell, which sits after this block.
//
// Before any client is acknowledged, the enable stays high for WakeCycles
// cycles. This gives the gated clock time to settle. When every request
// has gone away, the enable stays high for IdleCycles more cycles before
// the clock is gated off.
//
// Ports
//   clk_i        free-running clock
//   rst_ni       asynchronous active-low reset
//   req_i        level request per client, held until the client is done
//   force_on_i   keeps the clock enabled; acts as a requester with no ack
//   ack_o        per-client grant; the gated clock is stable while high
//   en_o         enable to the clock gate cell (registered-state decode)
//   busy_o       sequencer is not in OFF
//   off_pulse_o  one-cycle pulse on the first OFF cycle after HOLD
// ---------------------------------------------------------------------------
module prim_clock_gate_ctrl #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned WakeCycles = 2,
  parameter int unsigned IdleCycles = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              force_on_i,
  output logic [NumReq-1:0] ack_o,
  output logic              en_o,
  output logic              busy_o,
  output logic              off_pulse_o
);

  localparam int unsigned MaxCycles = (WakeCycles > IdleCycles) ? WakeCycles : IdleCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StWake = 2'd1,
    StOn   = 2'd2,
    StHold = 2'd3
  } state_e;

  state_e          state_reg, state_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic            off_pulse_reg, off_pulse_next;
  logic            any_req;
  logic            grant_window;

  assign any_req = (|req_i) | force_on_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= StOff;
      cnt_reg       <= '0;
      off_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      off_pulse_reg <= off_pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      StOff: begin
        if (any_req) begin
          state_next = StWake;
          cnt_next   = WakeLoad;
        end
      end

      // WAKE always runs to completion. A request that drops during
      // settling is simply not acknowledged later.
      StWake: begin
        if (cnt_reg == '0) begin
          state_next = StOn;
        end else begin
          cnt_next = cnt_reg - CntW'(1);
        end
      end

      StOn: begin
        if (!any_req) begin
          state_next = StHold;
          cnt_next   = IdleLoad;
        end
      end

      // A returning request wins over the counter expiring. The clock is
      // still running, so the client can be acknowledged straight away.
      StHold: begin
        if (any_req) begin
          state_next = StOn;
        end else if (cnt_reg == '0) begin
          state_next = StOff;
        end else begin
          cnt_next = cnt_reg - CntW'(1);
        end
      end

      default: begin
        state_next = StOff;
        cnt_next   = '0;
      end
    endcase
  end

  // The pulse is registered, so it lines up with the first OFF cycle.
  assign off_pulse_next = (state_reg == StHold) && (state_next == StOff);

  // The enable decodes registered state only. No input reaches the gate
  // cell through a combinational path, so it cannot glitch.
  assign en_o        = (state_reg != StOff);
  assign busy_o      = (state_reg != StOff);
  assign off_pulse_o = off_pulse_reg;

  // The ack is combinational from req_i. A client's ack therefore falls in
  // the same cycle as its request.
  assign grant_window = (state_reg == StOn);

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ack
    assign ack_o[gi] = req_i[gi] & grant_window;
  end

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// tb_prim_clock_gate_ctrl
// Cycle-by-cycle vectors hold inputs and expected outputs for one cycle.
// The driver applies each vector just after a rising edge and queues its
// expectation. A monitor pops the expectation at the falling edge and
// compares it with the outputs. Asynchronous reset is checked by hand in
// the middle of a cycle. The parameters are NumReq=4, WakeCycles=2 and
// IdleCycles=3.
module tb_prim_clock_gate_ctrl;

  logic       clk;
  logic       rst_ni;
  logic [3:0] req_i;
  logic       force_on_i;
  logic [3:0] ack_o;
  logic       en_o;
  logic       busy_o;
  logic       off_pulse_o;

  prim_clock_gate_ctrl #(
    .NumReq    (4),
    .WakeCycles(2),
    .IdleCycles(3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .force_on_i (force_on_i),
    .ack_o      (ack_o),
    .en_o       (en_o),
    .busy_o     (busy_o),
    .off_pulse_o(off_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] ack;
    logic       en;
    logic       busy;
    logic       pulse;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic       en;
    logic       busy;
    logic       pulse;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_x;
  int   checks   = 0;
  int   failures = 0;
  int   push_idx = 0;

  function automatic vec_t mk(logic r, logic [3:0] q, logic f,
                              logic [3:0] a, logic e, logic b, logic p);
    vec_t v;
    v.rst_n    = r;
    v.req      = q;
    v.force_on = f;
    v.ack      = a;
    v.en       = e;
    v.busy     = b;
    v.pulse    = p;
    return v;
  endfunction

  // Drive a vector just after the rising edge. Optionally queue its
  // expectation for the monitor.
  task automatic apply(input vec_t v, input bit push);
    exp_t x;
    @(posedge clk);
    #1;
    rst_ni     = v.rst_n;
    req_i      = v.req;
    force_on_i = v.force_on;
    if (push) begin
      x.ack   = v.ack;
      x.en    = v.en;
      x.busy  = v.busy;
      x.pulse = v.pulse;
      x.idx   = push_idx;
      sb.push_back(x);
    end
    push_idx++;
  endtask

  task automatic check_now(input string name, input logic [6:0] exp);
    checks++;
    if ({ack_o, en_o, busy_o, off_pulse_o} !== exp) begin
      failures++;
      $display("FAIL %s: ack=%b en=%b busy=%b off_pulse=%b, expected ack=%b en=%b busy=%b off_pulse=%b",
               name, ack_o, en_o, busy_o, off_pulse_o, exp[6:3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: ack=%b en=%b busy=%b off_pulse=%b", name, ack_o, en_o, busy_o, off_pulse_o);
    end
  endtask

  // Scoreboard monitor: compare at the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_x = sb.pop_front();
        checks++;
        if ({ack_o, en_o, busy_o, off_pulse_o} !== {mon_x.ack, mon_x.en, mon_x.busy, mon_x.pulse}) begin
          failures++;
          $display("FAIL vec%0d: ack=%b en=%b busy=%b off_pulse=%b, expected ack=%b en=%b busy=%b off_pulse=%b",
                   mon_x.idx, ack_o, en_o, busy_o, off_pulse_o,
                   mon_x.ack, mon_x.en, mon_x.busy, mon_x.pulse);
        end else begin
          $display("ok   vec%0d: ack=%b en=%b busy=%b off_pulse=%b",
                   mon_x.idx, ack_o, en_o, busy_o, off_pulse_o);
        end
      end
    end
  end

  initial begin
    rst_ni     = 1'b0;
    req_i      = 4'b0000;
    force_on_i = 1'b0;

    //                 rst req     frc  ack     en busy pulse
    // Reset held, then idle.
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    // Cold request: req in c0, WAKE c1-c2, ack from c3.
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0)); // c0 OFF
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0)); // c1 WAKE
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0)); // c2 WAKE
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 1, 1, 0)); // c3 ON
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 1, 1, 0)); // c4 ON
    // Idle gate-off: drop in c5, HOLD c6-c8, OFF+pulse c9.
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // c5 ON, ack low
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // c6 HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // c7 HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // c8 HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 1)); // c9 OFF pulse
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0)); // c10 OFF
    // Re-request in the second HOLD cycle.
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 0, 0, 0)); // c0 OFF
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // ON, drop
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD 1
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 1, 1, 0)); // HOLD 2, re-request
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 1, 1, 0)); // ON, ack next cycle
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // ON, drop
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 1)); // OFF pulse
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0)); // OFF
    // Request pulse in OFF: full WAKE, 1 ON, 3 HOLD, OFF, no ack.
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0)); // OFF pulse req
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 1)); // OFF pulse
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0)); // OFF
    // Force with multi-client toggling.
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0, 0)); // OFF, force
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b1010, 1, 4'b1010, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b1010, 1, 4'b1010, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // ON, force released
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 1)); // OFF pulse
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0)); // OFF
    // Request in the last HOLD cycle beats the expiring counter.
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 0, 0, 0)); // OFF
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 1, 1, 0)); // WAKE
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // ON, drop
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD cnt 2
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD cnt 1
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 1, 1, 0)); // HOLD cnt 0 + req
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1, 1, 0)); // ON
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // ON, drop
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0)); // HOLD
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 1)); // OFF pulse
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0)); // OFF

    #1;
    check_now("reset_values", 7'b0000_000);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], 1'b1);
    end

    // Async reset in the middle of WAKE.
    apply(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0), 1'b1); // c0 OFF
    apply(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0), 1'b0); // c1 WAKE
    #2;
    check_now("in_wake", 7'b0000_110);
    rst_ni = 1'b0;
    #1;
    check_now("rst_mid_wake", 7'b0000_000);
    apply(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0), 1'b1);
    apply(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0), 1'b1);
    apply(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0), 1'b1); // release: c0
    apply(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0), 1'b1); // WAKE
    apply(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0), 1'b1); // WAKE
    apply(mk(1, 4'b0001, 0, 4'b0001, 1, 1, 0), 1'b1); // ON
    // Async reset in the middle of ON.
    apply(mk(1, 4'b0001, 0, 4'b0001, 1, 1, 0), 1'b0);
    #2;
    check_now("in_on", 7'b0001_110);
    rst_ni = 1'b0;
    #1;
    check_now("rst_mid_on", 7'b0000_000);
    apply(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0), 1'b1);
    apply(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0), 1'b1); // release: c0
    apply(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0), 1'b1); // WAKE
    apply(mk(1, 4'b0001, 0, 4'b0000, 1, 1, 0), 1'b1); // WAKE
    apply(mk(1, 4'b0001, 0, 4'b0001, 1, 1, 0), 1'b1); // ON
    apply(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0), 1'b1); // ON, drop
    apply(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0), 1'b1); // HOLD
    apply(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0), 1'b1); // HOLD
    apply(mk(1, 4'b0000, 0, 4'b0000, 1, 1, 0), 1'b1); // HOLD
    apply(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 1), 1'b1); // OFF pulse
    apply(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0), 1'b1); // OFF

    // Give the monitor a bounded time to drain the scoreboard.
    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
